// File: rtl/adma_descriptor_fetch.sv
// ADMA descriptor fetch: reads one 96-bit descriptor as three 32-bit beats
// over an enb/ack memory port, then reports Valid and error status.
module adma_descriptor_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [63:0] sys_adr,
  input  logic        abort,
  output logic        mem_rd_enb,
  output logic [63:0] mem_rd_addr,
  input  logic        mem_rd_ack,
  input  logic [31:0] mem_rd_data,
  output logic        busy,
  output logic        desc_ready,
  output logic [95:0] descriptor_line,
  output logic        desc_invalid,
  output logic        fetch_error
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_CHECK,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   base_q, base_d;
  logic [1:0]    beat_q, beat_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          mem_rd_enb_q, mem_rd_enb_d;
  logic [63:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic          busy_q, busy_d;
  logic          desc_ready_q, desc_ready_d;
  logic [95:0]   line_q, line_d;
  logic          desc_invalid_q, desc_invalid_d;
  logic          fetch_error_q, fetch_error_d;
  logic [1:0]    beat_inc;
  logic [CW-1:0] tmo_inc;

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    beat_d         = beat_q;
    tmo_d          = tmo_q;
    mem_rd_enb_d   = mem_rd_enb_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    desc_ready_d   = 1'b0;
    line_d         = line_q;
    desc_invalid_d = desc_invalid_q;
    fetch_error_d  = fetch_error_q;
    beat_inc       = beat_q + 2'd1;
    tmo_inc        = tmo_q + 1'b1;

    // Outputs are registered, so each one is set on the transition into the
    // state that owns it rather than while sitting in that state.
    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          base_d         = sys_adr;
          beat_d         = 2'd0;
          desc_invalid_d = 1'b0;
          fetch_error_d  = 1'b0;
          if (sys_adr[1:0] != 2'b00) begin
            state_d       = S_ERR;
            fetch_error_d = 1'b1;
            desc_ready_d  = 1'b1;
          end else begin
            state_d       = S_REQ;
            mem_rd_enb_d  = 1'b1;
            mem_rd_addr_d = sys_adr;
          end
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_ack) begin
          case (beat_q)
            2'd0:    line_d[31:0]  = mem_rd_data;
            2'd1:    line_d[63:32] = mem_rd_data;
            default: line_d[95:64] = mem_rd_data;
          endcase
          mem_rd_enb_d = 1'b0;
          state_d      = S_NEXT;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            mem_rd_enb_d  = 1'b0;
            state_d       = S_ERR;
            fetch_error_d = 1'b1;
            desc_ready_d  = 1'b1;
          end
        end
      end
      S_NEXT: begin
        if (beat_q < 2'd2) begin
          beat_d        = beat_inc;
          mem_rd_enb_d  = 1'b1;
          mem_rd_addr_d = base_q + 64'({beat_inc, 2'b00});
          state_d       = S_REQ;
        end else begin
          state_d        = S_CHECK;
          desc_ready_d   = 1'b1;
          desc_invalid_d = ~line_q[0];
        end
      end
      S_CHECK: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything above, including a same-cycle ack.
    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      mem_rd_enb_d   = 1'b0;
      desc_ready_d   = 1'b0;
      line_d         = line_q;
      desc_invalid_d = desc_invalid_q;
      fetch_error_d  = fetch_error_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      beat_q         <= '0;
      tmo_q          <= '0;
      mem_rd_enb_q   <= 1'b0;
      mem_rd_addr_q  <= '0;
      busy_q         <= 1'b0;
      desc_ready_q   <= 1'b0;
      line_q         <= '0;
      desc_invalid_q <= 1'b0;
      fetch_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      beat_q         <= beat_d;
      tmo_q          <= tmo_d;
      mem_rd_enb_q   <= mem_rd_enb_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      busy_q         <= busy_d;
      desc_ready_q   <= desc_ready_d;
      line_q         <= line_d;
      desc_invalid_q <= desc_invalid_d;
      fetch_error_q  <= fetch_error_d;
    end
  end

  assign mem_rd_enb      = mem_rd_enb_q;
  assign mem_rd_addr     = mem_rd_addr_q;
  assign busy            = busy_q;
  assign desc_ready      = desc_ready_q;
  assign descriptor_line = line_q;
  assign desc_invalid    = desc_invalid_q;
  assign fetch_error     = fetch_error_q;

endmodule

// File: tb/tb_adma_descriptor_fetch.sv
// Bench for adma_descriptor_fetch: a memory responder pops expected beat
// addresses from a scoreboard queue; each scenario task checks its results.
module tb_adma_descriptor_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [63:0] sys_adr = '0;
  logic        abort = 1'b0;
  logic        mem_rd_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        mem_rd_enb;
  logic [63:0] mem_rd_addr;
  logic        busy;
  logic        desc_ready;
  logic [95:0] descriptor_line;
  logic        desc_invalid;
  logic        fetch_error;

  adma_descriptor_fetch #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_req(fetch_req),
    .sys_adr(sys_adr),
    .abort(abort),
    .mem_rd_enb(mem_rd_enb),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .busy(busy),
    .desc_ready(desc_ready),
    .descriptor_line(descriptor_line),
    .desc_invalid(desc_invalid),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] exp_addr_q[$];
  logic [31:0] mem_words[$];
  logic [95:0] exp_line = '0;

  int ack_delay = 0;
  int hold_beat = -1;
  int abort_beat = -1;
  bit allow_drop = 1'b0;
  bit resp_off = 1'b0;
  bit abort_fired = 1'b0;
  int inject_at = 0;
  logic [63:0] inject_adr = '0;

  int seen = 0;
  int cur_beat = 0;
  int beats_started = 0;
  int enb_cycles = 0;
  int last_drop_cycles = 0;
  bit acked = 1'b0;
  logic [63:0] rise_addr = '0;
  logic [63:0] exp_a;

  // Memory responder and request scoreboard
  always @(negedge clk) begin
    abort = 1'b0;
    if (resp_off) begin
      seen = 0;
    end else begin
      mem_rd_ack = 1'b0;
      if (mem_rd_enb) begin
        if (seen == 0) begin
          cur_beat = beats_started;
          beats_started++;
          enb_cycles = 0;
          acked = 1'b0;
          rise_addr = mem_rd_addr;
          n_cmp++;
          if (exp_addr_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_req: got addr %h, required no request", mem_rd_addr);
          end else begin
            exp_a = exp_addr_q.pop_front();
            if (mem_rd_addr !== exp_a) begin
              n_mis++;
              $display("FAIL req_addr: got %h, required %h", mem_rd_addr, exp_a);
            end
          end
        end else begin
          n_cmp++;
          if (mem_rd_addr !== rise_addr) begin
            n_mis++;
            $display("FAIL addr_stable: got %h, required %h", mem_rd_addr, rise_addr);
          end
        end
        enb_cycles++;
        if (seen == ack_delay + 1 && cur_beat != hold_beat && !acked) begin
          mem_rd_ack = 1'b1;
          mem_rd_data = (mem_words.size() > 0) ? mem_words.pop_front() : 32'hDEAD_BEEF;
          acked = 1'b1;
          if (cur_beat == abort_beat) begin
            abort = 1'b1;
            abort_fired = 1'b1;
          end
        end
        seen++;
      end else begin
        if (seen != 0 && !acked) begin
          last_drop_cycles = enb_cycles;
          n_cmp++;
          if (!allow_drop) begin
            n_mis++;
            $display("FAIL enb_drop: enb fell before ack after %0d cycles, required held until ack", enb_cycles);
          end
        end
        seen = 0;
      end
    end
  end

  task automatic run_fetch(input logic [63:0] adr, input int max_cyc, output int lat, output bit got);
    @(negedge clk);
    fetch_req = 1'b1;
    sys_adr = adr;
    @(negedge clk);
    fetch_req = 1'b0;
    lat = 1;
    got = 1'b0;
    while (lat <= max_cyc) begin
      if (desc_ready) begin
        got = 1'b1;
        break;
      end
      if (inject_at != 0 && lat == inject_at) begin
        fetch_req = 1'b1;
        sys_adr = inject_adr;
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({mem_rd_enb, busy, desc_ready, desc_invalid, fetch_error} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_flags: got %b, required 00000", {mem_rd_enb, busy, desc_ready, desc_invalid, fetch_error});
    end
    n_cmp++;
    if (mem_rd_addr !== 64'h0 || descriptor_line !== 96'h0) begin
      n_mis++;
      $display("FAIL reset_data: got addr %h line %h, required 0", mem_rd_addr, descriptor_line);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_aligned();
    int lat;
    bit got;
    logic [95:0] want;
    want = 96'h00000001_80000000_00100021;
    beats_started = 0;
    ack_delay = 0;
    exp_addr_q.push_back(64'h1000);
    exp_addr_q.push_back(64'h1004);
    exp_addr_q.push_back(64'h1008);
    mem_words.push_back(32'h0010_0021);
    mem_words.push_back(32'h8000_0000);
    mem_words.push_back(32'h0000_0001);
    run_fetch(64'h1000, 40, lat, got);
    n_cmp++;
    if (!got) begin n_mis++; $display("FAIL v1_ready: no desc_ready within 40 cycles, required pulse"); end
    n_cmp++;
    if (lat != 10) begin n_mis++; $display("FAIL v1_latency: got %0d, required 10", lat); end
    n_cmp++;
    if (descriptor_line !== want) begin n_mis++; $display("FAIL v1_line: got %h, required %h", descriptor_line, want); end
    n_cmp++;
    if ({desc_invalid, fetch_error, busy} !== 3'b001) begin
      n_mis++;
      $display("FAIL v1_status: got inv/err/busy %b, required 001", {desc_invalid, fetch_error, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({desc_ready, busy} !== 2'b00) begin n_mis++; $display("FAIL v1_pulse_end: got ready/busy %b, required 00", {desc_ready, busy}); end
    n_cmp++;
    if (exp_addr_q.size() != 0) begin n_mis++; $display("FAIL v1_reqs: %0d requests missing, required 0", exp_addr_q.size()); end
    exp_line = want;
  endtask

  task automatic test_wait_states();
    int lat;
    bit got;
    logic [95:0] want;
    want = 96'h00000001_80000000_00100020;
    beats_started = 0;
    ack_delay = 5;
    inject_at = 4;
    inject_adr = 64'h3002;
    exp_addr_q.push_back(64'h1000);
    exp_addr_q.push_back(64'h1004);
    exp_addr_q.push_back(64'h1008);
    mem_words.push_back(32'h0010_0020);
    mem_words.push_back(32'h8000_0000);
    mem_words.push_back(32'h0000_0001);
    run_fetch(64'h1000, 60, lat, got);
    inject_at = 0;
    ack_delay = 0;
    n_cmp++;
    if (!got || lat != 25) begin n_mis++; $display("FAIL v2_latency: got ready=%0d lat=%0d, required ready=1 lat=25", got, lat); end
    n_cmp++;
    if (descriptor_line !== want) begin n_mis++; $display("FAIL v2_line: got %h, required %h", descriptor_line, want); end
    n_cmp++;
    if ({desc_invalid, fetch_error} !== 2'b10) begin
      n_mis++;
      $display("FAIL v2_status: got inv/err %b, required 10", {desc_invalid, fetch_error});
    end
    @(negedge clk);
    n_cmp++;
    if (beats_started != 3 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL v2_ignored_req: got beats=%0d busy=%b, required beats=3 busy=0", beats_started, busy);
    end
    exp_line = want;
  endtask

  task automatic test_misaligned();
    int lat;
    bit got;
    beats_started = 0;
    run_fetch(64'h1002, 10, lat, got);
    n_cmp++;
    if (!got || lat > 2) begin n_mis++; $display("FAIL v3_ready: got ready=%0d lat=%0d, required ready within 2", got, lat); end
    n_cmp++;
    if ({fetch_error, desc_invalid} !== 2'b10) begin
      n_mis++;
      $display("FAIL v3_status: got err/inv %b, required 10", {fetch_error, desc_invalid});
    end
    n_cmp++;
    if (descriptor_line !== exp_line) begin n_mis++; $display("FAIL v3_line: got %h, required %h", descriptor_line, exp_line); end
    @(negedge clk);
    n_cmp++;
    if (beats_started != 0 || {desc_ready, busy, mem_rd_enb} !== 3'b000) begin
      n_mis++;
      $display("FAIL v3_no_req: got beats=%0d ready/busy/enb=%b, required 0 000", beats_started, {desc_ready, busy, mem_rd_enb});
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit got;
    beats_started = 0;
    hold_beat = 1;
    allow_drop = 1'b1;
    exp_addr_q.push_back(64'h2000);
    exp_addr_q.push_back(64'h2004);
    mem_words.push_back(32'hCAFE_0001);
    run_fetch(64'h2000, 40, lat, got);
    n_cmp++;
    if (!got || lat != 13) begin n_mis++; $display("FAIL v4_latency: got ready=%0d lat=%0d, required ready=1 lat=13", got, lat); end
    n_cmp++;
    if ({fetch_error, desc_invalid} !== 2'b10) begin
      n_mis++;
      $display("FAIL v4_status: got err/inv %b, required 10", {fetch_error, desc_invalid});
    end
    n_cmp++;
    if (descriptor_line !== {exp_line[95:32], 32'hCAFE_0001}) begin
      n_mis++;
      $display("FAIL v4_line: got %h, required %h", descriptor_line, {exp_line[95:32], 32'hCAFE_0001});
    end
    @(negedge clk);
    n_cmp++;
    if (last_drop_cycles != 9 || beats_started != 2) begin
      n_mis++;
      $display("FAIL v4_enb_cycles: got %0d enb cycles %0d beats, required 9 (1 REQ + 8 WAIT) 2 beats", last_drop_cycles, beats_started);
    end
    hold_beat = -1;
    allow_drop = 1'b0;
    exp_line[31:0] = 32'hCAFE_0001;
  endtask

  task automatic test_abort();
    int cyc;
    int readies;
    int lat;
    bit got;
    logic [95:0] want;
    beats_started = 0;
    abort_fired = 1'b0;
    abort_beat = 1;
    exp_addr_q.push_back(64'h4000);
    exp_addr_q.push_back(64'h4004);
    mem_words.push_back(32'h1234_0003);
    mem_words.push_back(32'h5555_AAAA);
    @(negedge clk);
    fetch_req = 1'b1;
    sys_adr = 64'h4000;
    @(negedge clk);
    fetch_req = 1'b0;
    cyc = 0;
    #1;
    while (!abort_fired && cyc < 30) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    abort_beat = -1;
    n_cmp++;
    if (!abort_fired) begin n_mis++; $display("FAIL v5_abort_point: beat-1 ack not reached in 30 cycles, required reached"); end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, mem_rd_enb} !== 2'b00) begin n_mis++; $display("FAIL v5_idle: got busy/enb %b, required 00", {busy, mem_rd_enb}); end
    readies = 0;
    repeat (12) begin
      if (desc_ready) readies++;
      @(negedge clk);
    end
    n_cmp++;
    if (readies != 0) begin n_mis++; $display("FAIL v5_no_ready: got %0d pulses, required 0", readies); end
    n_cmp++;
    if (descriptor_line !== {exp_line[95:32], 32'h1234_0003} || {desc_invalid, fetch_error} !== 2'b00) begin
      n_mis++;
      $display("FAIL v5_line: got %h inv/err %b, required %h 00", descriptor_line, {desc_invalid, fetch_error}, {exp_line[95:32], 32'h1234_0003});
    end
    mem_words.delete();
    exp_addr_q.delete();
    want = 96'h00000000_00000040_00000011;
    exp_addr_q.push_back(64'h5000);
    exp_addr_q.push_back(64'h5004);
    exp_addr_q.push_back(64'h5008);
    mem_words.push_back(32'h0000_0011);
    mem_words.push_back(32'h0000_0040);
    mem_words.push_back(32'h0000_0000);
    run_fetch(64'h5000, 40, lat, got);
    n_cmp++;
    if (!got || lat != 10 || descriptor_line !== want || desc_invalid !== 1'b0) begin
      n_mis++;
      $display("FAIL v5_refetch: got ready=%0d lat=%0d line=%h inv=%b, required 1 10 %h 0", got, lat, descriptor_line, desc_invalid, want);
    end
    exp_line = want;
  endtask

  task automatic test_wrap();
    int lat;
    bit got;
    logic [95:0] want;
    want = 96'hABCD0000_00000000_00000007;
    exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_addr_q.push_back(64'h0000_0000_0000_0000);
    mem_words.push_back(32'h0000_0007);
    mem_words.push_back(32'h0000_0000);
    mem_words.push_back(32'hABCD_0000);
    run_fetch(64'hFFFF_FFFF_FFFF_FFF8, 40, lat, got);
    n_cmp++;
    if (!got || lat != 10 || fetch_error !== 1'b0) begin
      n_mis++;
      $display("FAIL wrap_status: got ready=%0d lat=%0d err=%b, required 1 10 0", got, lat, fetch_error);
    end
    n_cmp++;
    if (descriptor_line !== want) begin n_mis++; $display("FAIL wrap_line: got %h, required %h", descriptor_line, want); end
    exp_line = want;
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    beats_started = 0;
    exp_addr_q.push_back(64'h6000);
    exp_addr_q.push_back(64'h6004);
    exp_addr_q.push_back(64'h6008);
    mem_words.push_back(32'h1111_0001);
    mem_words.push_back(32'h2222_0000);
    mem_words.push_back(32'h3333_0000);
    @(negedge clk);
    fetch_req = 1'b1;
    sys_adr = 64'h6000;
    @(negedge clk);
    fetch_req = 1'b0;
    cyc = 0;
    #1;
    while (beats_started < 3 && cyc < 30) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (beats_started != 3 || mem_rd_enb !== 1'b1) begin
      n_mis++;
      $display("FAIL v6_beat2: got beats=%0d enb=%b, required 3 1", beats_started, mem_rd_enb);
    end
    resp_off = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd_enb, busy, desc_ready, desc_invalid, fetch_error} !== 5'b0 || mem_rd_addr !== 64'h0 || descriptor_line !== 96'h0) begin
      n_mis++;
      $display("FAIL v6_async_reset: got flags %b addr %h line %h, required all 0",
               {mem_rd_enb, busy, desc_ready, desc_invalid, fetch_error}, mem_rd_addr, descriptor_line);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_addr_q.delete();
    mem_words.delete();
    @(negedge clk);
    mem_rd_ack = 1'b1;
    mem_rd_data = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rd_ack = 1'b0;
    n_cmp++;
    if ({busy, mem_rd_enb, desc_ready} !== 3'b000 || descriptor_line !== 96'h0) begin
      n_mis++;
      $display("FAIL v6_late_ack: got busy/enb/ready %b line %h, required 000 0", {busy, mem_rd_enb, desc_ready}, descriptor_line);
    end
    resp_off = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_aligned();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_abort();
    test_wrap();
    test_reset_mid_fetch();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
